// File: rtl/upsample_nn.sv
// Nearest-neighbour vector upsampler: each input beat is repeated S times and each row S times.
// Optional zero-insert mode is compiled in with UPSAMPLE_ZERO_INSERT_EN (adds zero_fill).
module upsample_nn #(
  parameter int SZI       = 16,
  parameter int A_WIDTH   = 8,
  parameter int MAX_W     = 256,
  parameter int MAX_SCALE = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [$clog2(MAX_SCALE):0]   scale,
`ifdef UPSAMPLE_ZERO_INSERT_EN
  input  logic                         zero_fill,
`endif
  input  logic [SZI*A_WIDTH-1:0]       d_value,
  input  logic                         d_valid,
  input  logic                         d_last_w,
  input  logic                         d_last_elm,
  output logic                         d_ready,
  output logic [SZI*A_WIDTH-1:0]       q_value,
  output logic                         q_valid,
  output logic                         q_last_w,
  output logic                         q_last_elm,
  input  logic                         q_ready,
  output logic                         busy
);
  localparam int DW = SZI * A_WIDTH;
  localparam int SW = $clog2(MAX_SCALE) + 1;
  localparam int CW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d, copy_q, copy_d, rep_q, rep_d;
  logic [CW-1:0]   col_q, col_d, lenm1_q, lenm1_d, rcol_q, rcol_d;
  logic            zf_q, zf_d, tend_q, tend_d;
  logic [DW-1:0]   q_value_q, q_value_d;
  logic            q_valid_q, q_valid_d, q_last_w_q, q_last_w_d, q_last_elm_q, q_last_elm_d;
  logic            load, last_copy, row_end, mem_we, zf_start;
  logic [SW-1:0]   scale_eff;
  logic [DW-1:0]   mem [MAX_W];
  logic [DW-1:0]   rd_q;

`ifdef UPSAMPLE_ZERO_INSERT_EN
  assign zf_start = zero_fill;
`else
  assign zf_start = 1'b0;
`endif

  // rd_q always tracks mem[rcol_q]; rcol only moves on a load, so the next load sees fresh data
  always_ff @(posedge clk) begin
    if (mem_we) mem[col_q] <= d_value;
    rd_q <= mem[rcol_d];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      s_q          <= SW'(1);
      copy_q       <= '0;
      rep_q        <= '0;
      col_q        <= '0;
      lenm1_q      <= '0;
      rcol_q       <= '0;
      zf_q         <= 1'b0;
      tend_q       <= 1'b0;
      q_value_q    <= '0;
      q_valid_q    <= 1'b0;
      q_last_w_q   <= 1'b0;
      q_last_elm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      copy_q       <= copy_d;
      rep_q        <= rep_d;
      col_q        <= col_d;
      lenm1_q      <= lenm1_d;
      rcol_q       <= rcol_d;
      zf_q         <= zf_d;
      tend_q       <= tend_d;
      q_value_q    <= q_value_d;
      q_valid_q    <= q_valid_d;
      q_last_w_q   <= q_last_w_d;
      q_last_elm_q <= q_last_elm_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    zf_d         = zf_q;
    col_d        = col_q;
    lenm1_d      = lenm1_q;
    copy_d       = copy_q;
    rcol_d       = rcol_q;
    rep_d        = rep_q;
    tend_d       = tend_q;
    q_value_d    = q_value_q;
    q_valid_d    = q_valid_q;
    q_last_w_d   = q_last_w_q;
    q_last_elm_d = q_last_elm_q;
    mem_we       = 1'b0;
    if (load) begin
      q_valid_d    = 1'b0;
      q_last_w_d   = 1'b0;
      q_last_elm_d = 1'b0;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        s_d     = scale_eff;
        zf_d    = zf_start;
        col_d   = '0;
        copy_d  = '0;
        rcol_d  = '0;
        rep_d   = '0;
      end
      FILL: if (d_valid && load) begin
        q_valid_d = 1'b1;
        q_value_d = (zf_q && copy_q != '0) ? '0 : d_value;
        mem_we    = (copy_q == '0);
        if (last_copy) begin
          copy_d = '0;
          if (row_end) begin
            q_last_w_d = 1'b1;
            lenm1_d    = col_q;
            col_d      = '0;
            if (s_q != SW'(1)) begin
              state_d = REPLAY;
              rcol_d  = '0;
              rep_d   = SW'(1);
              tend_d  = d_last_elm;
            end else if (d_last_elm) begin
              q_last_elm_d = 1'b1;
              state_d      = IDLE;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          copy_d = copy_q + 1'b1;
        end
      end
      REPLAY: if (load) begin
        q_valid_d = 1'b1;
        q_value_d = zf_q ? '0 : rd_q;
        if (last_copy) begin
          copy_d = '0;
          if (rcol_q == lenm1_q) begin
            rcol_d     = '0;
            q_last_w_d = 1'b1;
            if (rep_q == s_q - 1'b1) begin
              rep_d = '0;
              if (tend_q) begin
                q_last_elm_d = 1'b1;
                state_d      = IDLE;
              end else begin
                state_d = FILL;
              end
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end else begin
            rcol_d = rcol_q + 1'b1;
          end
        end else begin
          copy_d = copy_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load      = !q_valid_q || q_ready;
    last_copy = (copy_q == s_q - 1'b1);
    row_end   = d_last_w || d_last_elm || (col_q == CW'(MAX_W - 1));
    if (scale == '0)                   scale_eff = SW'(1);
    else if (scale > SW'(MAX_SCALE))   scale_eff = SW'(MAX_SCALE);
    else                               scale_eff = scale;
    d_ready    = (state_q == FILL) && last_copy && load;
    busy       = (state_q != IDLE);
    q_value    = q_value_q;
    q_valid    = q_valid_q;
    q_last_w   = q_last_w_q;
    q_last_elm = q_last_elm_q;
  end

endmodule

// File: doc/upsample_nn.md
UPSAMPLE_NN -- requirements
Module: upsample_nn

Interface
REQ-001 SHALL have parameter SZI, default 16: vector lanes per beat.
REQ-002 SHALL have parameter A_WIDTH, default 8: bits per lane.
REQ-003 SHALL have parameter MAX_W, default 256: max row length in beats; line-buffer depth.
REQ-004 SHALL have parameter MAX_SCALE, default 4: max upsample factor.
REQ-005 SHALL have port clk  in  1: clock.
REQ-006 SHALL have port resetn  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1: one-cycle pulse; latches config, begins a tile.
REQ-008 SHALL have port scale  in  $clog2(MAX_SCALE)+1: upsample factor; 0 is treated as 1.
REQ-009 SHALL have port d_value  in  SZI*A_WIDTH: input vector.
REQ-010 SHALL have ports d_valid, d_last_w, d_last_elm  in  1 each: valid, end of row, end of tile.
REQ-011 SHALL have port d_ready  out  1: input beat accepted when d_valid & d_ready.
REQ-012 SHALL have port q_value  out  SZI*A_WIDTH: output vector.
REQ-013 SHALL have ports q_valid, q_last_w, q_last_elm  out  1 each: valid, end of output row, end of output tile.
REQ-014 SHALL have port q_ready  in  1: output beat consumed when q_valid & q_ready.
REQ-015 SHALL have port busy  out  1: high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE, FILL, REPLAY; start in IDLE latches scale (and zero_fill, REQ-032) and enters FILL; start outside IDLE is ignored.
REQ-017 SHALL, in FILL, emit each accepted input beat S=scale times consecutively; d_ready is high only on copy S-1 while the output register can load (q_valid==0 or q_ready).
REQ-018 SHALL write d_value into line buffer at column col when copy 0 loads; col increments per input beat and is captured as row length L on d_last_w.
REQ-019 SHALL use a registered output stage: first copy appears on q_value one cycle after the input beat is present with the register free; q_* hold stable while q_valid & !q_ready.
REQ-020 SHALL, after the row ending with d_last_w, enter REPLAY if S>1, else remain in FILL (or go IDLE if d_last_elm).
REQ-021 SHALL, in REPLAY, read the line buffer columns 0..L-1, emit each S times, repeating the whole row S-1 times; no input accepted (d_ready=0).
REQ-022 SHALL assert q_last_w on the last copy of the last column of every output row (S per input row).
REQ-023 SHALL assert q_last_elm only on the final beat of the final replayed row of an input row that carried d_last_elm, then return to IDLE; otherwise REPLAY returns to FILL with col=0.
REQ-024 SHALL produce exactly S*S*L output beats per input row of L beats, none dropped or duplicated under any q_ready pattern.
REQ-025 SHALL, for S=1, be a pass-through: one output per input, q_last_w/q_last_elm copy d_last_w/d_last_elm, throughput one beat per cycle when q_ready stays high.
REQ-026 SHALL, if col reaches MAX_W without d_last_w, force end-of-row at MAX_W-1 (wrap col to 0).
REQ-027 SHALL, if d_last_elm arrives without d_last_w, treat that beat as also ending the row.

Reset
REQ-028 SHALL, on resetn low, asynchronously clear: state to IDLE, q_valid, q_last_w, q_last_elm, d_ready, busy to 0, q_value to 0, col, copy and replay counters to 0.
REQ-029 SHALL not require line-buffer contents cleared; reset mid-REPLAY abandons the row and no further q_valid occurs until a new start.
REQ-030 SHALL resume operation on the first clk edge after resetn deasserts.

Configuration
REQ-031 SHALL compile zero-insert mode only when macro UPSAMPLE_ZERO_INSERT_EN is defined.
REQ-032 SHALL, with UPSAMPLE_ZERO_INSERT_EN, add input port zero_fill (1 bit, latched at start): when set, copies 1..S-1 and all REPLAY beats output value 0 while flags/counts are unchanged (transposed-conv stride insertion).
REQ-033 SHALL, without UPSAMPLE_ZERO_INSERT_EN, omit zero_fill and always replicate.

Verification
REQ-034 SHALL cover: S=2, one row d=1,2,3 (last_w+last_elm on 3), q_ready=1 -> q=1,1,2,2,3,3,1,1,2,2,3,3; q_last_w on beats 6,12; q_last_elm on beat 12 only; then IDLE.
REQ-035 SHALL cover: same stimulus, q_ready toggling 1,0,0,1 repeating -> identical 12-beat sequence, q_value stable during stalls.
REQ-036 SHALL cover: S=1, 4 beats 5,6,7,8 -> q=5,6,7,8 back-to-back, q_last_w/q_last_elm on beat 4.
REQ-037 SHALL cover: UPSAMPLE_ZERO_INSERT_EN, zero_fill=1, S=2, d=1,2,3 -> q=1,0,2,0,3,0 then six 0s, flags as REQ-034.
REQ-038 SHALL cover: resetn pulse during REPLAY beat 8 of REQ-034 -> q_valid=0 next cycle, busy=0; second start with S=3 yields 27 beats for a 3-beat row.
REQ-039 SHALL cover: start pulsed during FILL -> ignored, scale unchanged, output count unchanged.
